escape_game_ctrl: RTL

- Central game sequencer for the Morse escape-room design, replacing the ad-hoc mode mux in the top level.
- Consumes decoded-letter strobes from the Morse trie decoder, checks them against a per-level target word, and tracks lives and a countdown timer.
- Drives the display-select code that chooses which VGA page renderer reaches the screen.

---
 rtl/escape_game_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/escape_game_ctrl.sv
// Game sequencer for the Morse escape room: matches decoded letters against the
// per-level target word, tracks lives and a per-attempt countdown, selects the VGA page.
//
// state    | meaning
// S_IDLE   | start page, waiting for practice switch or start with a level chosen
// S_PRACTICE | free practice page, letters ignored
// S_PLAY   | attempt in progress on the latched level
// S_WON    | word completed, waiting for start
// S_LOST   | out of lives or time, waiting for start
module escape_game_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 60,
  parameter int MAX_LIVES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mode_practice,
  input  logic [2:0] i_lvl_sel,
  input  logic       i_start,
  input  logic [7:0] i_letter,
  input  logic       i_letter_valid,
  output logic [2:0] o_display_sel,
  output logic [2:0] o_progress,
  output logic [1:0] o_lives,
  output logic [6:0] o_secs_left,
  output logic [2:0] o_lvl_won,
  output logic       o_mistake
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_HZ - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [6:0]    SECS_INIT  = 7'(TIMEOUT_S);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRACTICE,
    S_PLAY,
    S_WON,
    S_LOST
  } state_t;

  state_t r_state, w_state_n;

  logic [1:0]    r_lvl, w_lvl_n;
  logic [2:0]    r_prog, w_prog_n;
  logic [1:0]    r_lives, w_lives_n;
  logic [6:0]    r_secs, w_secs_n;
  logic [PW-1:0] r_pre, w_pre_n;
  logic [2:0]    r_won, w_won_n;
  logic          r_mistake, w_mistake_n;
  logic [2:0]    r_disp, w_disp_n;

  logic          w_tick;
  logic          w_match;
  logic          w_done;
  logic          w_lose;

  // Target words: L1 HELP, L2 OPEN, L3 EXIT
  function automatic logic [7:0] target_char(input logic [1:0] lvl, input logic [1:0] idx);
    logic [7:0] c;
    case ({lvl, idx})
      4'b00_00: c = "H";
      4'b00_01: c = "E";
      4'b00_10: c = "L";
      4'b00_11: c = "P";
      4'b01_00: c = "O";
      4'b01_01: c = "P";
      4'b01_10: c = "E";
      4'b01_11: c = "N";
      4'b10_00: c = "E";
      4'b10_01: c = "X";
      4'b10_10: c = "I";
      4'b10_11: c = "T";
      default:  c = 8'h00;
    endcase
    return c;
  endfunction

  assign w_tick  = (r_pre == PRE_MAX);
  assign w_match = (i_letter == target_char(r_lvl, r_prog[1:0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lvl     <= 2'd0;
      r_prog    <= 3'd0;
      r_lives   <= LIVES_INIT;
      r_secs    <= SECS_INIT;
      r_pre     <= '0;
      r_won     <= 3'b000;
      r_mistake <= 1'b0;
      r_disp    <= 3'd0;
    end else begin
      r_state   <= w_state_n;
      r_lvl     <= w_lvl_n;
      r_prog    <= w_prog_n;
      r_lives   <= w_lives_n;
      r_secs    <= w_secs_n;
      r_pre     <= w_pre_n;
      r_won     <= w_won_n;
      r_mistake <= w_mistake_n;
      r_disp    <= w_disp_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_lvl_n     = r_lvl;
    w_prog_n    = r_prog;
    w_lives_n   = r_lives;
    w_secs_n    = r_secs;
    w_pre_n     = r_pre;
    w_won_n     = r_won;
    w_mistake_n = 1'b0;
    w_done      = 1'b0;
    w_lose      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_mode_practice) begin
          w_state_n = S_PRACTICE;
        end else if (i_start && (i_lvl_sel != 3'b000)) begin
          w_state_n = S_PLAY;
          if (i_lvl_sel[0])      w_lvl_n = 2'd0;
          else if (i_lvl_sel[1]) w_lvl_n = 2'd1;
          else                   w_lvl_n = 2'd2;
          w_prog_n  = 3'd0;
          w_lives_n = LIVES_INIT;
          w_secs_n  = SECS_INIT;
          w_pre_n   = '0;
        end
      end

      S_PRACTICE: begin
        if (!i_mode_practice) w_state_n = S_IDLE;
      end

      S_PLAY: begin
        w_pre_n = w_tick ? '0 : r_pre + PW'(1);
        if (i_letter_valid) begin
          if (w_match) begin
            w_prog_n = (r_prog == 3'd4) ? r_prog : r_prog + 3'd1;
            w_done   = (r_prog == 3'd3);
          end else begin
            w_mistake_n = 1'b1;
            w_prog_n    = 3'd0;
            w_lives_n   = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            w_lose      = (r_lives <= 2'd1);
          end
        end
        // A completing letter wins outright even on the final tick.
        if (w_done) begin
          w_state_n = S_WON;
          w_won_n   = r_won | (3'b001 << r_lvl);
        end else begin
          if (w_tick) begin
            w_secs_n = (r_secs == 7'd0) ? 7'd0 : r_secs - 7'd1;
            if (r_secs <= 7'd1) w_lose = 1'b1;
          end
          if (w_lose) w_state_n = S_LOST;
        end
      end

      S_WON, S_LOST: begin
        if (i_start) w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_disp_n = 3'd0;
    case (w_state_n)
      S_IDLE:     w_disp_n = 3'd0;
      S_PRACTICE: w_disp_n = 3'd1;
      S_PLAY:     w_disp_n = 3'd2 + {1'b0, w_lvl_n};
      S_WON:      w_disp_n = 3'd5;
      S_LOST:     w_disp_n = 3'd6;
      default:    w_disp_n = 3'd0;
    endcase
  end

  assign o_display_sel = r_disp;
  assign o_progress    = r_prog;
  assign o_lives       = r_lives;
  assign o_secs_left   = r_secs;
  assign o_lvl_won     = r_won;
  assign o_mistake     = r_mistake;

endmodule
